mips_dmem_responder: RTL

//   Data-memory responder for the MIPS processor's load/store path. Accepts
//   one word read/write request at a time via valid/ready, inserts a fixed

---
 rtl/mips_dmem_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mips_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mips_dmem_responder                                            |
// | Brief   : Multi-cycle word data memory with valid/ready request side,    |
// |           fixed wait states and a one-cycle response strobe.             |
// | Options : MISALIGN_CHECK_EN - reject byte addresses not word aligned     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mips_dmem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          c_depth    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  c_waitLast = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_waitCnt;
  logic                    r_write;
  logic                    r_err;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic [31:0]             r_readData;
  logic [31:0]             r_mem [c_depth];

  logic                    w_rangeErr;
  logic                    w_alignErr;
  logic                    w_reqErr;
  logic                    w_accept;
  logic                    w_enterResp;
  logic                    w_fromInputs;
  logic                    w_write;
  logic                    w_err;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [31:0]             w_wdata;

  assign w_rangeErr = |req_addr[31:ADDR_WIDTH+2];

`ifdef MISALIGN_CHECK_EN
  assign w_alignErr = |req_addr[1:0];
`else
  // Byte offset is ignored: the access lands on the containing word.
  logic w_unusedAddrLo;
  assign w_unusedAddrLo = |req_addr[1:0];
  assign w_alignErr     = 1'b0;
`endif

  assign w_reqErr = w_rangeErr | w_alignErr;
  assign w_accept = (r_state == IDLE) && req_valid;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // array must be addressed from the live request rather than the captures.
  assign w_enterResp  = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == WAIT) && (r_waitCnt == c_waitLast));
  assign w_fromInputs = (r_state == IDLE);
  assign w_write      = w_fromInputs ? req_write                   : r_write;
  assign w_err        = w_fromInputs ? w_reqErr                    : r_err;
  assign w_idx        = w_fromInputs ? req_addr[ADDR_WIDTH+1:2]    : r_idx;
  assign w_wdata      = w_fromInputs ? req_wdata                   : r_wdata;

  // Array is never reset; an aborted request cannot reach this edge because
  // the state machine drops to IDLE asynchronously.
  always_ff @(posedge clk) begin
    if (w_enterResp && !reset) begin
      if (w_write && !w_err) begin
        r_mem[w_idx] <= w_wdata;
      end
      r_readData <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_waitCnt <= 4'd0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= 32'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write   <= req_write;
            r_err     <= w_reqErr;
            r_idx     <= req_addr[ADDR_WIDTH+1:2];
            r_wdata   <= req_wdata;
            r_waitCnt <= 4'd0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            r_state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (r_waitCnt == c_waitLast) begin
            r_state <= RESP;
          end else begin
            r_waitCnt <= r_waitCnt + 4'd1;
          end
        end
        RESP: begin
          // Response strobe is registered out of RESP and so appears in the
          // first IDLE cycle, alongside req_ready.
          r_state   <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= r_err;
          rsp_rdata <= (r_write || r_err) ? 32'd0 : r_readData;
        end
        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
